// File: rtl/garage_door_ctrl_v2.sv
// garage_door_ctrl_v2
//   Garage door motor controller. Turns a wall-button / remote level into
//   single rising-edge commands and drives the motor up or down. It also
//   handles obstruction reversal and a motor-off dead-time before any change
//   of direction. A move that takes too long, or contradictory limit
//   switches, latch a fault. An optional auto-close timer is provided.
//
// Ports
//   CLK       in   system clock
//   RST       in   synchronous, active-high reset
//   Activate  in   button/remote level; only rising edges act
//   UP_MAX    in   fully-open limit switch, active high
//   DOWN_MAX  in   fully-closed limit switch, active high
//   OBSTRUCT  in   IR beam broken, active high
//   UP_M      out  drive motor up   (only in OPENING)
//   DOWN_M    out  drive motor down (only in CLOSING)
//   FAULT     out  latched fault indicator
//   STATE     out  current state encoding (debug/status)
//
// Parameters
//   MOVE_TIMEOUT  max cycles in OPENING/CLOSING before FAULT (>= 2)
//   REV_DELAY     dead-time cycles in DWELL before moving (>= 1)
//   AUTO_CLOSE    cycles in OPEN before automatic close, 0 = disabled
//   CNT_W         width of the shared cycle counter
module garage_door_ctrl_v2 #(
  parameter int MOVE_TIMEOUT = 1000,
  parameter int REV_DELAY    = 16,
  parameter int AUTO_CLOSE   = 0,
  parameter int CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Activate,
  input  logic       UP_MAX,
  input  logic       DOWN_MAX,
  input  logic       OBSTRUCT,
  output logic       UP_M,
  output logic       DOWN_M,
  output logic       FAULT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_CLOSED  = 3'd1,
    S_OPENING = 3'd2,
    S_OPEN    = 3'd3,
    S_CLOSING = 3'd4,
    S_STOPPED = 3'd5,
    S_DWELL   = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  // Direction encoding shared by last_dir and the DWELL target.
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Counter values at which the respective timed transition fires.
  localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_RD_LAST = CNT_W'(REV_DELAY - 1);
  localparam logic [CNT_W-1:0] L_AC_LAST = CNT_W'((AUTO_CLOSE == 0) ? 0 : AUTO_CLOSE - 1);
  localparam logic             L_AC_EN   = (AUTO_CLOSE != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_act_q;
  logic             r_last_dir;
  logic             r_target;

  state_t           w_next_state;
  logic             w_next_last_dir;
  logic             w_next_target;
  logic             w_cnt_clr;
  logic             w_edge;
  logic             w_dwell_tgt;
  logic [CNT_W-1:0] w_cnt_next;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] all_ones;
    all_ones = '1;
    return (v == all_ones) ? v : v + CNT_W'(1);
  endfunction

  assign w_edge = Activate & ~r_act_q;

  // An obstruction while in DWELL heading down flips the target to up;
  // the dead-time already served still counts.
  assign w_dwell_tgt = ((r_target == DIR_DN) && OBSTRUCT) ? DIR_UP : r_target;

  always_comb begin
    w_next_state    = r_state;
    w_next_last_dir = r_last_dir;
    w_next_target   = r_target;
    w_cnt_clr       = 1'b0;
    if (UP_MAX && DOWN_MAX) begin
      // Both limits at once is physically impossible: sensor fault.
      w_next_state = S_FAULT;
    end else begin
      case (r_state)
        S_INIT: begin
          if (DOWN_MAX) begin
            w_next_state = S_CLOSED;
          end else if (UP_MAX) begin
            w_next_state = S_OPEN;
          end else begin
            // Unknown position: pretend we were last going up so the
            // first command closes the door.
            w_next_state    = S_STOPPED;
            w_next_last_dir = DIR_UP;
          end
        end
        S_CLOSED: begin
          if (w_edge) begin
            w_next_state    = S_OPENING;
            w_next_last_dir = DIR_UP;
          end
        end
        S_OPENING: begin
          if (UP_MAX) begin
            w_next_state = S_OPEN;
          end else if (r_cnt == L_TO_LAST) begin
            w_next_state = S_FAULT;
          end else if (w_edge) begin
            w_next_state = S_STOPPED;
          end
        end
        S_OPEN: begin
          if (OBSTRUCT) begin
            // Beam broken: hold open and restart the auto-close wait.
            w_cnt_clr = 1'b1;
          end else if ((L_AC_EN && (r_cnt == L_AC_LAST)) || w_edge) begin
            w_next_state  = S_DWELL;
            w_next_target = DIR_DN;
          end
        end
        S_CLOSING: begin
          if (DOWN_MAX) begin
            w_next_state = S_CLOSED;
          end else if (OBSTRUCT) begin
            w_next_state  = S_DWELL;
            w_next_target = DIR_UP;
          end else if (r_cnt == L_TO_LAST) begin
            w_next_state = S_FAULT;
          end else if (w_edge) begin
            w_next_state = S_STOPPED;
          end
        end
        S_STOPPED: begin
          if (w_edge) begin
            w_next_state  = S_DWELL;
            w_next_target = ~r_last_dir;
          end
        end
        S_DWELL: begin
          w_next_target = w_dwell_tgt;
          if (r_cnt == L_RD_LAST) begin
            w_next_state    = (w_dwell_tgt == DIR_UP) ? S_OPENING : S_CLOSING;
            w_next_last_dir = w_dwell_tgt;
          end
        end
        S_FAULT: begin
          w_next_state = S_FAULT;
        end
        default: begin
          w_next_state = S_INIT;
        end
      endcase
    end
  end

  assign w_cnt_next = ((w_next_state != r_state) || w_cnt_clr) ? '0 : sat_inc(r_cnt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_INIT;
      r_cnt      <= '0;
      r_act_q    <= 1'b0;
      r_last_dir <= DIR_UP;
      r_target   <= DIR_DN;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_cnt_next;
      r_act_q    <= Activate;
      r_last_dir <= w_next_last_dir;
      r_target   <= w_next_target;
    end
  end

  // Moore outputs straight from the state register.
  assign UP_M   = (r_state == S_OPENING);
  assign DOWN_M = (r_state == S_CLOSING);
  assign FAULT  = (r_state == S_FAULT);
  assign STATE  = r_state;

endmodule

// File: tb/tb_garage_door_ctrl_v2.sv
// Testbench for garage_door_ctrl_v2 (MOVE_TIMEOUT=8, REV_DELAY=4, AUTO_CLOSE=20).
// Stimulus pushes the state expected after the next clock edge; a monitor
// pops one expectation per cycle and compares all outputs.
module tb_garage_door_ctrl_v2;

  logic       CLK;
  logic       RST;
  logic       Activate;
  logic       UP_MAX;
  logic       DOWN_MAX;
  logic       OBSTRUCT;
  logic       UP_M;
  logic       DOWN_M;
  logic       FAULT;
  logic [2:0] STATE;

  localparam logic [2:0] ST_INIT = 3'd0, ST_CLOSED = 3'd1, ST_OPENING = 3'd2,
                         ST_OPEN = 3'd3, ST_CLOSING = 3'd4, ST_STOPPED = 3'd5,
                         ST_DWELL = 3'd6, ST_FAULT = 3'd7;

  typedef struct {
    logic [2:0] st;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  garage_door_ctrl_v2 #(
    .MOVE_TIMEOUT(8),
    .REV_DELAY   (4),
    .AUTO_CLOSE  (20),
    .CNT_W       (16)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Activate(Activate),
    .UP_MAX  (UP_MAX),
    .DOWN_MAX(DOWN_MAX),
    .OBSTRUCT(OBSTRUCT),
    .UP_M    (UP_M),
    .DOWN_M  (DOWN_M),
    .FAULT   (FAULT),
    .STATE   (STATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Monitor: one expectation per clock edge, checked 1 time unit after it.
  initial begin
    exp_t e;
    logic eu, ed, ef;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        eu = (e.st == ST_OPENING);
        ed = (e.st == ST_CLOSING);
        ef = (e.st == ST_FAULT);
        n_cmp++;
        if (STATE !== e.st || UP_M !== eu || DOWN_M !== ed || FAULT !== ef) begin
          n_bad++;
          $display("FAIL %s: got STATE=%0d UP_M=%b DOWN_M=%b FAULT=%b, want STATE=%0d UP_M=%b DOWN_M=%b FAULT=%b",
                   e.nm, STATE, UP_M, DOWN_M, FAULT, e.st, eu, ed, ef);
        end
      end
    end
  end

  // Drive inputs for the next edge, record the expected result, advance.
  task automatic step(input logic rst, input logic act, input logic up,
                      input logic dn, input logic obs,
                      input logic [2:0] st, input string nm);
    exp_t e;
    RST      = rst;
    Activate = act;
    UP_MAX   = up;
    DOWN_MAX = dn;
    OBSTRUCT = obs;
    e.st = st;
    e.nm = nm;
    q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; Activate = 1'b0; UP_MAX = 1'b0; DOWN_MAX = 1'b0; OBSTRUCT = 1'b0;
    @(posedge CLK);
    #2;

    // Power-up closed, open fully.
    step(1, 0, 0, 1, 0, ST_INIT,    "reset");
    step(0, 0, 0, 1, 0, ST_CLOSED,  "init_to_closed");
    step(0, 1, 0, 1, 0, ST_OPENING, "closed_edge_opening");
    step(0, 0, 0, 0, 0, ST_OPENING, "opening_travel");
    step(0, 0, 1, 0, 0, ST_OPEN,    "up_max_open");

    // Close with dead-time, edge in DWELL ignored, then obstruction reversal.
    step(0, 0, 1, 0, 0, ST_OPEN,    "open_hold");
    step(0, 1, 1, 0, 0, ST_DWELL,   "open_edge_dwell");
    step(0, 0, 1, 0, 0, ST_DWELL,   "dwell_c1");
    step(0, 1, 1, 0, 0, ST_DWELL,   "dwell_c2_edge_ignored");
    step(0, 0, 1, 0, 0, ST_DWELL,   "dwell_c3");
    step(0, 0, 0, 0, 0, ST_CLOSING, "dwell_to_closing");
    step(0, 0, 0, 0, 0, ST_CLOSING, "closing_travel");
    step(0, 0, 0, 0, 1, ST_DWELL,   "obstruct_reversal");
    step(0, 0, 0, 0, 0, ST_DWELL,   "rev_dwell_c1");
    step(0, 0, 0, 0, 0, ST_DWELL,   "rev_dwell_c2");
    step(0, 0, 0, 0, 0, ST_DWELL,   "rev_dwell_c3");
    step(0, 0, 0, 0, 0, ST_OPENING, "rev_dwell_to_opening");

    // Mid-travel stop, then a long press that must act only once.
    step(0, 0, 0, 0, 0, ST_OPENING, "reopen_travel");
    step(0, 1, 0, 0, 0, ST_STOPPED, "opening_edge_stopped");
    step(0, 1, 0, 0, 0, ST_STOPPED, "stopped_held_no_edge");
    step(0, 0, 0, 0, 0, ST_STOPPED, "stopped_idle");
    step(0, 1, 0, 0, 0, ST_DWELL,   "stopped_edge_dwell");
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, 0, ST_DWELL, $sformatf("held_dwell_%0d", i));
    step(0, 1, 0, 0, 0, ST_CLOSING, "held_dwell_to_closing");
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, 0, ST_CLOSING, $sformatf("held_closing_%0d", i));

    // No DOWN_MAX: timeout fires 8 edges after CLOSING was entered.
    step(0, 0, 0, 0, 0, ST_CLOSING, "closing_release_6");
    step(0, 0, 0, 0, 0, ST_CLOSING, "closing_7");
    step(0, 0, 0, 0, 0, ST_FAULT,   "closing_timeout_fault");
    step(0, 1, 0, 0, 0, ST_FAULT,   "fault_ignores_edge");
    step(0, 0, 0, 0, 0, ST_FAULT,   "fault_latched");
    step(0, 1, 0, 0, 0, ST_FAULT,   "fault_ignores_edge2");
    step(1, 0, 0, 0, 0, ST_INIT,    "rst_clears_fault");

    // Unknown position: first command closes.
    step(0, 0, 0, 0, 0, ST_STOPPED, "init_unknown_stopped");
    step(0, 1, 0, 0, 0, ST_DWELL,   "init_first_edge_dwell");
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, 0, ST_DWELL, $sformatf("init_dwell_%0d", i));
    step(0, 0, 0, 0, 0, ST_CLOSING, "init_dwell_to_closing");

    // Limit switch and edge together: limit wins, no re-open.
    step(0, 1, 0, 1, 0, ST_CLOSED,  "down_max_beats_edge");
    step(0, 1, 0, 1, 0, ST_CLOSED,  "closed_held_no_edge");
    step(0, 0, 0, 1, 0, ST_CLOSED,  "closed_stays");

    // Auto-close restarted by an obstruction at OPEN cycle 10.
    step(0, 1, 0, 1, 0, ST_OPENING, "open2_edge");
    step(0, 0, 0, 0, 0, ST_OPENING, "open2_travel");
    step(0, 0, 1, 0, 0, ST_OPEN,    "open2_reached");
    for (int i = 1; i <= 9; i++) step(0, 0, 1, 0, 0, ST_OPEN, $sformatf("ac_wait_%0d", i));
    step(0, 0, 1, 0, 1, ST_OPEN,    "ac_obstruct_restart");
    for (int i = 1; i <= 19; i++) step(0, 0, 1, 0, 0, ST_OPEN, $sformatf("ac_rewait_%0d", i));
    step(0, 0, 1, 0, 0, ST_DWELL,   "auto_close_dwell");

    // Obstruction during a closing dwell retargets to opening, same timing.
    step(0, 0, 1, 0, 1, ST_DWELL,   "ac_dwell_obstruct");
    step(0, 0, 1, 0, 0, ST_DWELL,   "ac_dwell_c2");
    step(0, 0, 1, 0, 0, ST_DWELL,   "ac_dwell_c3");
    step(0, 0, 0, 0, 0, ST_OPENING, "ac_dwell_to_opening");

    // Contradictory limits while opening.
    step(0, 0, 1, 1, 0, ST_FAULT,   "both_limits_fault");
    step(1, 0, 0, 0, 0, ST_INIT,    "final_reset");

    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
